// File: rtl/mips_multicycle_pkg.sv
// Shared types and encodings for the multicycle MIPS controller: FSM states, opcodes,
// R-type funct codes and ALU control values.
package mips_multicycle_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecute,
    StAluWb,
    StBranch,
    StAddiEx,
    StAddiWb,
    StJump
  } state_e;

  typedef enum logic [1:0] {
    AluOpAdd,
    AluOpSub,
    AluOpFunct
  } alu_op_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  localparam logic [2:0] AluCtrlAdd = 3'b010;
  localparam logic [2:0] AluCtrlSub = 3'b110;
  localparam logic [2:0] AluCtrlAnd = 3'b000;
  localparam logic [2:0] AluCtrlOr  = 3'b001;
  localparam logic [2:0] AluCtrlSlt = 3'b111;

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the controller's ALUOp plus the instruction funct field to an ALU control code.
module mc_alu_decoder
  import mips_multicycle_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  alu_op_e               alu_op_i,
  input  logic [5:0]            funct_i,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic                  illegal_funct_o
);

  logic [2:0] ctrl;

  always_comb begin
    ctrl            = AluCtrlAdd;
    illegal_funct_o = 1'b0;
    unique case (alu_op_i)
      AluOpSub:   ctrl = AluCtrlSub;
      AluOpFunct: begin
        case (funct_i)
          FunctAdd: ctrl = AluCtrlAdd;
          FunctSub: ctrl = AluCtrlSub;
          FunctAnd: ctrl = AluCtrlAnd;
          FunctOr:  ctrl = AluCtrlOr;
          FunctSlt: ctrl = AluCtrlSlt;
          default:  illegal_funct_o = 1'b1;
        endcase
      end
      default:    ctrl = AluCtrlAdd;
    endcase
  end

  assign alu_control_o = ALU_CTRL_W'(ctrl);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM (lw/sw/R-type/beq/addi/j) with a unified, ready-handshaked memory.
module mips_multicycle_ctrl
  import mips_multicycle_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [5:0]            op_i,
  input  logic [5:0]            funct_i,
  input  logic                  zero_i,
  input  logic                  mem_ready_i,
  output logic                  mem_req_o,
  output logic                  iord_o,
  output logic                  mem_write_o,
  output logic                  ir_write_o,
  output logic                  pc_en_o,
  output logic [1:0]            pc_src_o,
  output logic                  alu_src_a_o,
  output logic [1:0]            alu_src_b_o,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic                  reg_dst_o,
  output logic                  memto_reg_o,
  output logic                  reg_write_o,
  output logic                  instr_done_o,
  output logic                  illegal_o
);

  state_e                state_q, state_d;
  alu_op_e               alu_op;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  illegal_funct;

  logic       mem_req, iord, mem_write, ir_write, pc_en, alu_src_a;
  logic       reg_dst, memto_reg, reg_write, instr_done, illegal;
  logic [1:0] pc_src, alu_src_b;

  mc_alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_decoder (
    .alu_op_i       (alu_op),
    .funct_i        (funct_i),
    .alu_control_o  (alu_ctrl),
    .illegal_funct_o(illegal_funct)
  );

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = AluOpAdd;
    reg_dst    = 1'b0;
    memto_reg  = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready_i;
        pc_en     = mem_ready_i;
        if (mem_ready_i) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        case (op_i)
          OpLw, OpSw: state_d = StMemAdr;
          OpRType:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            state_d    = StFetch;
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_i == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready_i) state_d = StMemWb;
      end
      StMemWb: begin
        memto_reg  = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        // The write strobe is qualified by ready so a stalled store never writes twice.
        mem_req    = 1'b1;
        iord       = 1'b1;
        mem_write  = mem_ready_i;
        instr_done = mem_ready_i;
        if (mem_ready_i) state_d = StFetch;
      end
      StExecute: begin
        alu_src_a = 1'b1;
        alu_op    = AluOpFunct;
        illegal   = illegal_funct;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alu_src_a  = 1'b1;
        alu_op     = AluOpSub;
        pc_src     = 2'b01;
        pc_en      = zero_i;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StJump: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset gates every output so FETCH does not present a memory request while held in reset.
  assign mem_req_o     = rst_ni & mem_req;
  assign iord_o        = rst_ni & iord;
  assign mem_write_o   = rst_ni & mem_write;
  assign ir_write_o    = rst_ni & ir_write;
  assign pc_en_o       = rst_ni & pc_en;
  assign pc_src_o      = rst_ni ? pc_src : 2'b00;
  assign alu_src_a_o   = rst_ni & alu_src_a;
  assign alu_src_b_o   = rst_ni ? alu_src_b : 2'b00;
  assign alu_control_o = rst_ni ? alu_ctrl : '0;
  assign reg_dst_o     = rst_ni & reg_dst;
  assign memto_reg_o   = rst_ni & memto_reg;
  assign reg_write_o   = rst_ni & reg_write;
  assign instr_done_o  = rst_ni & instr_done;
  assign illegal_o     = rst_ni & illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected output vectors are queued as
// stimulus is driven and compared on the following falling edge.
module tb_mips_multicycle_ctrl;

  typedef enum int {
    SFetch, SDecode, SMemAdr, SMemRd, SMemWb, SMemWr,
    SExec, SAluWb, SBranch, SAddiEx, SAddiWb, SJump
  } tst_e;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [5:0] op_i = 6'b0;
  logic [5:0] funct_i = 6'b0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;

  logic       mem_req_o, iord_o, mem_write_o, ir_write_o, pc_en_o, alu_src_a_o;
  logic       reg_dst_o, memto_reg_o, reg_write_o, instr_done_o, illegal_o;
  logic [1:0] pc_src_o, alu_src_b_o;
  logic [2:0] alu_control_o;

  logic [17:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  mips_multicycle_ctrl #(
    .ALU_CTRL_W(3)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .op_i         (op_i),
    .funct_i      (funct_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .mem_req_o    (mem_req_o),
    .iord_o       (iord_o),
    .mem_write_o  (mem_write_o),
    .ir_write_o   (ir_write_o),
    .pc_en_o      (pc_en_o),
    .pc_src_o     (pc_src_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_control_o(alu_control_o),
    .reg_dst_o    (reg_dst_o),
    .memto_reg_o  (memto_reg_o),
    .reg_write_o  (reg_write_o),
    .instr_done_o (instr_done_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  logic [17:0] dut_vec;
  assign dut_vec = {mem_req_o, iord_o, mem_write_o, ir_write_o, pc_en_o, pc_src_o, alu_src_a_o,
                    alu_src_b_o, alu_control_o, reg_dst_o, memto_reg_o, reg_write_o,
                    instr_done_o, illegal_o};

  // Vector order: mreq iord mwr irw pcen pcsrc[2] srca srcb[2] alu[3] rdst m2r rwr done ill
  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b required %b", tag, got, exp);
  endtask

  function automatic logic [17:0] exp_out(input tst_e st, input logic [5:0] op,
                                          input logic [5:0] funct, input logic zero,
                                          input logic ready);
    logic       mreq, iord, mwr, irw, pcen, srca, rdst, m2r, rwr, done, ill;
    logic [1:0] pcsrc, srcb;
    logic [2:0] alu;
    {mreq, iord, mwr, irw, pcen, srca, rdst, m2r, rwr, done, ill} = '0;
    pcsrc = 2'b00;
    srcb  = 2'b00;
    alu   = 3'b010;
    case (st)
      SFetch:  begin mreq = 1; srcb = 2'b01; irw = ready; pcen = ready; end
      SDecode: begin
        srcb = 2'b11;
        if (!(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010}))
          begin ill = 1; done = 1; end
      end
      SMemAdr: begin srca = 1; srcb = 2'b10; end
      SMemRd:  begin mreq = 1; iord = 1; end
      SMemWb:  begin m2r = 1; rwr = 1; done = 1; end
      SMemWr:  begin mreq = 1; iord = 1; mwr = ready; done = ready; end
      SExec: begin
        srca = 1;
        case (funct)
          6'b100000: alu = 3'b010;
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default:   ill = 1;
        endcase
      end
      SAluWb:  begin rdst = 1; rwr = 1; done = 1; end
      SBranch: begin srca = 1; alu = 3'b110; pcsrc = 2'b01; pcen = zero; done = 1; end
      SAddiEx: begin srca = 1; srcb = 2'b10; end
      SAddiWb: begin rwr = 1; done = 1; end
      SJump:   begin pcsrc = 2'b10; pcen = 1; done = 1; end
      default: ;
    endcase
    return {mreq, iord, mwr, irw, pcen, pcsrc, srca, srcb, alu, rdst, m2r, rwr, done, ill};
  endfunction

  task automatic step(input tst_e st, input logic [5:0] op, input logic [5:0] funct,
                      input logic zero, input logic ready, input logic rst);
    @(posedge clk_i);
    #1;
    rst_ni      = rst;
    op_i        = op;
    funct_i     = funct;
    zero_i      = zero;
    mem_ready_i = ready;
    exp_q.push_back(rst ? exp_out(st, op, funct, zero, ready) : 18'b0);
    tag_q.push_back(rst ? $sformatf("%s op=%b f=%b", st.name(), op, funct) : "in_reset");
  endtask

  // One instruction with optional stall cycles in FETCH and in the memory-access state.
  task automatic instr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                       input int fetch_waits, input int mem_waits);
    for (int i = 0; i < fetch_waits; i++) step(SFetch, op, funct, zero, 1'b0, 1'b1);
    step(SFetch, op, funct, zero, 1'b1, 1'b1);
    step(SDecode, op, funct, zero, 1'b1, 1'b1);
    case (op)
      6'b100011: begin
        step(SMemAdr, op, funct, zero, 1'b1, 1'b1);
        for (int i = 0; i < mem_waits; i++) step(SMemRd, op, funct, zero, 1'b0, 1'b1);
        step(SMemRd, op, funct, zero, 1'b1, 1'b1);
        step(SMemWb, op, funct, zero, 1'b1, 1'b1);
      end
      6'b101011: begin
        step(SMemAdr, op, funct, zero, 1'b1, 1'b1);
        for (int i = 0; i < mem_waits; i++) step(SMemWr, op, funct, zero, 1'b0, 1'b1);
        step(SMemWr, op, funct, zero, 1'b1, 1'b1);
      end
      6'b000000: begin
        step(SExec, op, funct, zero, 1'b1, 1'b1);
        step(SAluWb, op, funct, zero, 1'b1, 1'b1);
      end
      6'b000100: step(SBranch, op, funct, zero, 1'b1, 1'b1);
      6'b001000: begin
        step(SAddiEx, op, funct, zero, 1'b1, 1'b1);
        step(SAddiWb, op, funct, zero, 1'b1, 1'b1);
      end
      6'b000010: step(SJump, op, funct, zero, 1'b1, 1'b1);
      default: ;
    endcase
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      logic [17:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, dut_vec, e);
    end
  end

  initial begin
    step(SFetch, 6'b100011, 6'b0, 1'b0, 1'b1, 1'b0);
    instr(6'b100011, 6'b000000, 1'b0, 0, 0);
    instr(6'b100011, 6'b000000, 1'b0, 2, 1);
    instr(6'b101011, 6'b000000, 1'b0, 0, 3);
    instr(6'b101011, 6'b000000, 1'b0, 0, 0);
    instr(6'b000000, 6'b100010, 1'b0, 0, 0);
    instr(6'b000000, 6'b100000, 1'b0, 0, 0);
    instr(6'b000000, 6'b100100, 1'b0, 0, 0);
    instr(6'b000000, 6'b100101, 1'b0, 0, 0);
    instr(6'b000000, 6'b101010, 1'b0, 0, 0);
    instr(6'b000000, 6'b000000, 1'b0, 0, 0);
    instr(6'b000100, 6'b000000, 1'b1, 0, 0);
    instr(6'b000100, 6'b000000, 1'b0, 0, 0);
    instr(6'b001000, 6'b000000, 1'b0, 0, 0);
    instr(6'b000010, 6'b000000, 1'b0, 1, 0);
    instr(6'b111111, 6'b000000, 1'b0, 0, 0);
    // Reset asserted while a load is stalled in MEMRD, then the load is re-run from FETCH.
    step(SFetch, 6'b100011, 6'b0, 1'b0, 1'b1, 1'b1);
    step(SDecode, 6'b100011, 6'b0, 1'b0, 1'b1, 1'b1);
    step(SMemAdr, 6'b100011, 6'b0, 1'b0, 1'b1, 1'b1);
    step(SMemRd, 6'b100011, 6'b0, 1'b0, 1'b0, 1'b1);
    step(SMemRd, 6'b100011, 6'b0, 1'b0, 1'b1, 1'b0);
    instr(6'b100011, 6'b000000, 1'b0, 0, 0);
    instr(6'b001000, 6'b000000, 1'b0, 0, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
